// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : bin_to_bcd_seq_if
// Purpose : Handshake/data bundle between a requester and the sequential
//           binary-to-BCD converter.
// Signals : start  requester -> converter  request a conversion of bin
//           bin    requester -> converter  WIDTH-bit binary value
//           busy   converter -> requester  conversion in progress
//           done   converter -> requester  one-cycle pulse, bcd/ovf updated
//           bcd    converter -> requester  packed BCD, digit 0 in [3:0]
//           ovf    converter -> requester  value did not fit in DIGITS digits
// Revision: 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();

  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  ovf
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output ovf
  );

endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin_to_bcd_seq
// Purpose : Sequential double-dabble converter. Accepts a WIDTH-bit binary
//           count and produces DIGITS packed BCD digits, one bit per clock,
//           with a start/busy/done handshake. Results are held between
//           conversions.
// Ports   : clk  in   rising-edge clock
//           rst  in   asynchronous reset, active-low
//           bus  slave modport of bin_to_bcd_seq_if (start, bin, busy, done,
//                bcd, ovf)
// Revision: 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  wire logic            clk,
  input  wire logic            rst,
  bin_to_bcd_seq_if.slave      bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DW    = 4 * DIGITS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   shift_q,    shift_d;
  logic [DW-1:0]      work_q,     work_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic               ovf_work_q, ovf_work_d;
  logic [DW-1:0]      bcd_q,      bcd_d;
  logic               ovf_q,      ovf_d;
  logic               done_q,     done_d;

  // Digits after the +3 correction, all digits in parallel.
  logic [DW-1:0]        w_adj;
  // Correction followed by the one-bit left shift of {digits, shift reg}.
  logic                 w_carry;
  logic [DW+WIDTH-1:0]  w_shifted;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                                (work_q[4*gi +: 4] + 4'd3) :
                                 work_q[4*gi +: 4];
    end
  endgenerate

  // Appending a zero and taking everything below the top bit performs the
  // left shift; the top bit is what falls out of the most significant digit.
  // This form also stays legal for WIDTH == 1.
  assign {w_carry, w_shifted} = {w_adj, shift_q, 1'b0};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    count_d    = count_q;
    ovf_work_d = ovf_work_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d    = bus.bin;
          work_d     = '0;
          count_d    = CNT_W'(WIDTH);
          ovf_work_d = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        work_d     = w_shifted[DW+WIDTH-1:WIDTH];
        shift_d    = w_shifted[WIDTH-1:0];
        ovf_work_d = ovf_work_q | w_carry;
        count_d    = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          // Publish using this iteration's results, not the stale work regs.
          bcd_d   = w_shifted[DW+WIDTH-1:WIDTH];
          ovf_d   = ovf_work_q | w_carry;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      count_q    <= '0;
      ovf_work_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      count_q    <= count_d;
      ovf_work_q <= ovf_work_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_bin_to_bcd_seq
// Purpose : Self-checking bench for bin_to_bcd_seq. One instance with
//           WIDTH=8/DIGITS=3 checked against a scoreboard plus vector table,
//           one instance with DIGITS=2 for the overflow case.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus8 ();
  bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) bus2 ();

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: decimal digits of bin mod 10^DIGITS.
  function automatic logic [11:0] model3(input int v);
    int m;
    m = v % 1000;
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // ---------------- scoreboard for the DIGITS=3 instance ----------------
  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst && bus8.start && !bus8.busy) begin
      e.bcd = model3(int'(bus8.bin));
      e.ovf = (int'(bus8.bin) >= 1000);
      e.due = cyc + 9;
      sb.push_back(e);
    end
    if (rst && bus8.done) begin
      if (sb.size() == 0) begin
        fail_now("sb_unexpected_done", cyc, -1);
      end else begin
        e = sb.pop_front();
        check("sb_bcd", int'(bus8.bcd), int'(e.bcd));
        check("sb_ovf", int'(bus8.ovf), int'(e.ovf));
        check("sb_done_cycle", cyc, e.due);
      end
    end
    if (sb.size() > 0 && cyc > sb[0].due) begin
      fail_now("sb_done_timeout", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  // ---------------- helpers ----------------
  // Pulse start for one accepting edge, then wait for done (bounded).
  task automatic run8(input int v, output int lat, output int busy_cnt);
    bus8.bin   = 8'(v);
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!bus8.done && lat < 30) begin
      if (bus8.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus8.done) fail_now("run8_timeout", lat, 8);
  endtask

  task automatic run2(input int v);
    int k;
    bus2.bin   = 8'(v);
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    k = 0;
    while (!bus2.done && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus2.done) fail_now("run2_timeout", k, 8);
  endtask

  task automatic wait_idle8();
    int k;
    k = 0;
    while (bus8.busy && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    if (bus8.busy) fail_now("wait_idle_timeout", k, 9);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() != 0) fail_now("drain_timeout", sb.size(), 0);
  endtask

  typedef struct {
    int          bin;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t v8[10];
  vec_t v2[6];

  initial begin
    int lat, bcnt, k, dcnt;

    v8[0] = '{0,   12'h000, 1'b0};
    v8[1] = '{1,   12'h001, 1'b0};
    v8[2] = '{9,   12'h009, 1'b0};
    v8[3] = '{10,  12'h010, 1'b0};
    v8[4] = '{99,  12'h099, 1'b0};
    v8[5] = '{100, 12'h100, 1'b0};
    v8[6] = '{128, 12'h128, 1'b0};
    v8[7] = '{200, 12'h200, 1'b0};
    v8[8] = '{254, 12'h254, 1'b0};
    v8[9] = '{255, 12'h255, 1'b0};

    v2[0] = '{123, 12'h023, 1'b1};
    v2[1] = '{42,  12'h042, 1'b0};
    v2[2] = '{99,  12'h099, 1'b0};
    v2[3] = '{100, 12'h000, 1'b1};
    v2[4] = '{255, 12'h055, 1'b1};
    v2[5] = '{0,   12'h000, 1'b0};

    bus8.start = 1'b0; bus8.bin = '0;
    bus2.start = 1'b0; bus2.bin = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset_busy", int'(bus8.busy), 0);
    check("reset_done", int'(bus8.done), 0);
    check("reset_bcd",  int'(bus8.bcd),  0);
    check("reset_ovf",  int'(bus8.ovf),  0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: 255, latency and busy length
    run8(255, lat, bcnt);
    check("t1_latency", lat, 8);
    check("t1_busy_cycles", bcnt, 8);
    check("t1_bcd", int'(bus8.bcd), 12'h255);
    check("t1_ovf", int'(bus8.ovf), 0);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run8(v8[i].bin, lat, bcnt);
      check("tbl8_bcd", int'(bus8.bcd), int'(v8[i].bcd));
      check("tbl8_ovf", int'(bus8.ovf), int'(v8[i].ovf));
      check("tbl8_latency", lat, 8);
    end
    @(posedge clk); #1;

    // 2: 99 then 100 started in the done cycle
    run8(99, lat, bcnt);
    check("t2_bcd_99", int'(bus8.bcd), 12'h099);
    bus8.bin   = 8'd100;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    check("t2_hold_99", int'(bus8.bcd), 12'h099);
    k = 1;
    while (!bus8.done && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("t2_gap", k, 9);
    check("t2_bcd_100", int'(bus8.bcd), 12'h100);
    drain();

    // 3: start held high, bin stepping 0..20 (scoreboard checks each result)
    bus8.start = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      bus8.bin = 8'(i);
      wait_idle8();
      @(posedge clk); #1;
    end
    bus8.start = 1'b0;
    drain();
    check("t3_last_bcd", int'(bus8.bcd), 12'h020);

    // 4: start pulse mid-conversion with a new bin is ignored
    bus8.bin   = 8'd200;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_hold_prev", int'(bus8.bcd), 12'h020);
    bus8.bin   = 8'd7;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    k = 0;
    while (!bus8.done && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("t4_bcd", int'(bus8.bcd), 12'h200);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus8.done) dcnt++;
    end
    check("t4_no_extra_done", dcnt, 0);
    check("t4_idle", int'(bus8.busy), 0);

    // 5: asynchronous reset in the middle of a conversion
    bus8.bin   = 8'd77;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b0;
    sb.delete();
    #1;
    check("t5_busy", int'(bus8.busy), 0);
    check("t5_done", int'(bus8.done), 0);
    check("t5_bcd",  int'(bus8.bcd),  0);
    check("t5_ovf",  int'(bus8.ovf),  0);
    @(posedge clk); #1;
    rst = 1'b1;
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus8.done) dcnt++;
      if (bus8.busy) bcnt++;
    end
    check("t5_stay_idle", bcnt, 0);
    check("t5_no_done", dcnt, 0);
    check("t5_bcd_after", int'(bus8.bcd), 0);

    // 6: DIGITS=2 instance, overflow behaviour
    for (int i = 0; i < 6; i++) begin
      run2(v2[i].bin);
      check("tbl2_bcd", int'(bus2.bcd), int'(v2[i].bcd[7:0]));
      check("tbl2_ovf", int'(bus2.ovf), int'(v2[i].ovf));
    end

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
